rob_mw: RTL and testbench

- Parametrised successor ROB: one circular entry array with wrap-bit head/tail pointers, instead of per-bank FIFOs.
- Each cycle it accepts up to IW in-order pushes from issue, up to WBW out-of-order writebacks by ROB id, and up to CW in-order commits.
- New relative to the prior ROB: occupancy counter, per-slot ready/empty status, multi-port writeback of result data, prefix-contiguous commit window, and an optional exception stop.
- Sits between issue/rename and the commit stage.

---
 rtl/rob_mw_pkg.sv | 20 ++
 rtl/rob_mw_if.sv | 65 ++++++
 rtl/rob_mw_chk.sv | 32 +++
 rtl/rob_mw_cmt_window.sv | 41 ++++
 rtl/rob_mw.sv | 153 +++++++++++++++
 tb/tb_rob_mw.sv | 235 +++++++++++++++++++++++
 6 files changed

// File: rtl/rob_mw_pkg.sv
// rob_mw_pkg: shared defaults and helpers for the rob_mw reorder buffer.
// Optional exception tracking is enabled by defining NCPU_ROB_EXC_EN.
package rob_mw_pkg;

  // Default geometry: log2 of issue/commit/writeback ports and of entries.
  localparam int DEF_P_ISSUE_WIDTH  = 1;
  localparam int DEF_P_COMMIT_WIDTH = 1;
  localparam int DEF_P_WB_WIDTH     = 1;
  localparam int DEF_P_ROB_DEPTH    = 4;

  // Default payload: EPU/LSU opcode, BPU update, PC, prd_we and PRF address.
  localparam int DEF_PAYLOAD_DW     = 96;
  localparam int DEF_CONFIG_DW      = 64;

  // Smaller of two unsigned quantities; used to clamp the pop request.
  function automatic int unsigned rob_min(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/rob_mw_if.sv
// rob_mw_if: issue, writeback and commit bundle of the rob_mw reorder buffer.
// NCPU_ROB_EXC_EN adds the per-writeback exception bit and per-commit flag.
interface rob_mw_if #(
  parameter int CONFIG_P_ISSUE_WIDTH  = 1,
  parameter int CONFIG_P_COMMIT_WIDTH = 1,
  parameter int CONFIG_P_WB_WIDTH     = 1,
  parameter int CONFIG_P_ROB_DEPTH    = 4,
  parameter int PAYLOAD_DW            = 96,
  parameter int CONFIG_DW             = 64
);
  localparam int IW  = 1 << CONFIG_P_ISSUE_WIDTH;
  localparam int CW  = 1 << CONFIG_P_COMMIT_WIDTH;
  localparam int WBW = 1 << CONFIG_P_WB_WIDTH;
  localparam int P_D = CONFIG_P_ROB_DEPTH;

  logic                            flush;
  logic [CONFIG_P_ISSUE_WIDTH:0]   push_size;
  logic [IW*PAYLOAD_DW-1:0]        push_payload;
  logic                            rob_ready;
  logic [IW*P_D-1:0]               rob_free_id;
  logic [WBW-1:0]                  wb_valid;
  logic [WBW*P_D-1:0]              wb_rob_id;
  logic [WBW*CONFIG_DW-1:0]        wb_data;
  logic [CW-1:0]                   cmt_valid;
  logic [CW*PAYLOAD_DW-1:0]        cmt_payload;
  logic [CW*CONFIG_DW-1:0]         cmt_data;
  logic [CW*P_D-1:0]               cmt_rob_id;
  logic [CONFIG_P_COMMIT_WIDTH:0]  cmt_pop_size;
  logic [P_D:0]                    rob_count;
  logic                            rob_empty;
`ifdef NCPU_ROB_EXC_EN
  logic [WBW-1:0]                  wb_exc;
  logic [CW-1:0]                   cmt_exc;
`endif

  // Pipeline side: drives issue/writeback/pop, observes the buffer.
  modport master (
    output flush, push_size, push_payload, wb_valid, wb_rob_id, wb_data, cmt_pop_size,
`ifdef NCPU_ROB_EXC_EN
    output wb_exc, input cmt_exc,
`endif
    input  rob_ready, rob_free_id, cmt_valid, cmt_payload, cmt_data, cmt_rob_id,
           rob_count, rob_empty
  );

  // Buffer side.
  modport slave (
    input  flush, push_size, push_payload, wb_valid, wb_rob_id, wb_data, cmt_pop_size,
`ifdef NCPU_ROB_EXC_EN
    input  wb_exc, output cmt_exc,
`endif
    output rob_ready, rob_free_id, cmt_valid, cmt_payload, cmt_data, cmt_rob_id,
           rob_count, rob_empty
  );

  // Passive observer for protocol checkers.
  modport mon (
    input  flush, push_size, push_payload, wb_valid, wb_rob_id, wb_data, cmt_pop_size,
`ifdef NCPU_ROB_EXC_EN
    input  wb_exc, cmt_exc,
`endif
    input  rob_ready, rob_free_id, cmt_valid, cmt_payload, cmt_data, cmt_rob_id,
           rob_count, rob_empty
  );
endinterface

// File: rtl/rob_mw_chk.sv
// rob_mw_chk: protocol checker for the rob_mw pipeline interface.
// i_en lets the environment mask deliberate protocol violations.
module rob_mw_chk #(
  parameter int CONFIG_P_COMMIT_WIDTH = 1,
  parameter int CONFIG_P_WB_WIDTH     = 1,
  parameter int CONFIG_P_ROB_DEPTH    = 4
) (
  input logic   clk,
  input logic   rst,
  input logic   i_en,
  rob_mw_if.mon io
);
  localparam int WBW = 1 << CONFIG_P_WB_WIDTH;
  localparam int P_D = CONFIG_P_ROB_DEPTH;

  // Flag pushes without space, over-pops and colliding writebacks.
  always_ff @(posedge clk) begin
    if (rst && i_en && !io.flush) begin
      assert (io.push_size == '0 || io.rob_ready)
        else $error("rob_mw_chk: push while rob_ready=0");
      assert (32'(io.cmt_pop_size) <= $countones(io.cmt_valid))
        else $error("rob_mw_chk: pop exceeds committable entries");
      for (int p = 0; p < WBW; p++) begin
        for (int q = p + 1; q < WBW; q++) begin
          assert (!(io.wb_valid[p] && io.wb_valid[q] &&
                    io.wb_rob_id[p*P_D +: P_D] == io.wb_rob_id[q*P_D +: P_D]))
            else $error("rob_mw_chk: two writebacks to one id");
        end
      end
    end
  end
endmodule

// File: rtl/rob_mw_cmt_window.sv
// rob_mw_cmt_window: prefix-contiguous commit window over a circular queue.
// Slot k is valid only if every slot before it is valid; an excepting entry
// may only be presented alone in slot 0. Purely combinational.
module rob_mw_cmt_window #(
  parameter int P_CW = 1,
  parameter int P_D  = 4
) (
  input  logic [P_D:0]              i_count,
  input  logic [P_D-1:0]            i_head,
  input  logic [(1 << P_D)-1:0]     i_rdy,
  input  logic [(1 << P_D)-1:0]     i_exc,
  output logic [(1 << P_CW)-1:0]    o_valid,
  output logic [P_CW:0]             o_vcnt
);
  localparam int CW   = 1 << P_CW;
  localparam int PTRW = P_D + 1;

  logic [P_D-1:0] w_idx;
  logic           w_in;
  logic           w_run;
  logic           w_exc_seen;

  // Walk the window from the head, breaking the prefix at the first gap.
  always_comb begin
    o_valid    = '0;
    o_vcnt     = '0;
    w_idx      = '0;
    w_in       = 1'b0;
    w_run      = 1'b1;
    w_exc_seen = 1'b0;
    for (int k = 0; k < CW; k++) begin
      w_idx      = i_head + P_D'(k);
      w_in       = (PTRW'(k) < i_count) && i_rdy[w_idx] &&
                   !((k != 0) && (i_exc[w_idx] || w_exc_seen));
      w_run      = w_run & w_in;
      o_valid[k] = w_run;
      o_vcnt     = o_vcnt + (P_CW+1)'(w_run);
      w_exc_seen = w_exc_seen | i_exc[w_idx];
    end
  end
endmodule

// File: rtl/rob_mw.sv
// rob_mw: multi-width reorder buffer on a single circular entry array.
// Wrap-bit head/tail pointers, registered occupancy, multi-port writeback,
// prefix-contiguous commit window. Define NCPU_ROB_EXC_EN for exception stop.
module rob_mw
  import rob_mw_pkg::*;
#(
  parameter int CONFIG_P_ISSUE_WIDTH  = DEF_P_ISSUE_WIDTH,
  parameter int CONFIG_P_COMMIT_WIDTH = DEF_P_COMMIT_WIDTH,
  parameter int CONFIG_P_WB_WIDTH     = DEF_P_WB_WIDTH,
  parameter int CONFIG_P_ROB_DEPTH    = DEF_P_ROB_DEPTH,
  parameter int PAYLOAD_DW            = DEF_PAYLOAD_DW,
  parameter int CONFIG_DW             = DEF_CONFIG_DW
) (
  input logic     clk,
  input logic     rst,
  rob_mw_if.slave io
);
  localparam int IW   = 1 << CONFIG_P_ISSUE_WIDTH;
  localparam int CW   = 1 << CONFIG_P_COMMIT_WIDTH;
  localparam int WBW  = 1 << CONFIG_P_WB_WIDTH;
  localparam int P_D  = CONFIG_P_ROB_DEPTH;
  localparam int D    = 1 << P_D;
  localparam int PTRW = P_D + 1;
  localparam int PIW1 = CONFIG_P_ISSUE_WIDTH + 1;
  localparam int PCW1 = CONFIG_P_COMMIT_WIDTH + 1;

  logic [PTRW-1:0]       r_head;
  logic [PTRW-1:0]       r_tail;
  logic [PTRW-1:0]       r_count;
  logic [D-1:0]          r_rdy;
  logic [D-1:0]          r_occ;
  logic [PAYLOAD_DW-1:0] r_payload [D];
  logic [CONFIG_DW-1:0]  r_data    [D];
`ifdef NCPU_ROB_EXC_EN
  logic [D-1:0]          r_exc;
`endif

  logic                  w_ready;
  logic [PIW1-1:0]       w_push_n;
  logic [PCW1-1:0]       w_pop_n;
  logic [PCW1-1:0]       w_vcnt;
  logic [CW-1:0]         w_valid;
  logic [D-1:0]          w_exc;

  // Exception bits seen by the window; constant zero when the feature is off.
`ifdef NCPU_ROB_EXC_EN
  assign w_exc = r_exc;
`else
  assign w_exc = '0;
`endif

  rob_mw_cmt_window #(
    .P_CW (CONFIG_P_COMMIT_WIDTH),
    .P_D  (P_D)
  ) u_cmt_window (
    .i_count (r_count),
    .i_head  (r_head[P_D-1:0]),
    .i_rdy   (r_rdy),
    .i_exc   (w_exc),
    .o_valid (w_valid),
    .o_vcnt  (w_vcnt)
  );

  // Space check on current occupancy only; effective push and clamped pop.
  always_comb begin
    w_ready  = (r_count <= PTRW'(D - IW));
    w_push_n = w_ready ? io.push_size : '0;
    w_pop_n  = PCW1'(rob_min(32'(io.cmt_pop_size), 32'(w_vcnt)));
  end

  // Status, allocation ids and commit window outputs from registered state.
  always_comb begin
    io.rob_ready   = w_ready;
    io.rob_count   = r_count;
    io.rob_empty   = (r_count == '0);
    io.cmt_valid   = w_valid;
    io.rob_free_id = '0;
    io.cmt_payload = '0;
    io.cmt_data    = '0;
    io.cmt_rob_id  = '0;
`ifdef NCPU_ROB_EXC_EN
    io.cmt_exc     = '0;
`endif
    for (int k = 0; k < IW; k++) begin
      io.rob_free_id[k*P_D +: P_D] = r_tail[P_D-1:0] + P_D'(k);
    end
    for (int k = 0; k < CW; k++) begin
      io.cmt_rob_id[k*P_D +: P_D]             = r_head[P_D-1:0] + P_D'(k);
      io.cmt_payload[k*PAYLOAD_DW +: PAYLOAD_DW] = r_payload[r_head[P_D-1:0] + P_D'(k)];
      io.cmt_data[k*CONFIG_DW +: CONFIG_DW]   = r_data[r_head[P_D-1:0] + P_D'(k)];
`ifdef NCPU_ROB_EXC_EN
      io.cmt_exc[k] = w_valid[k] & r_exc[r_head[P_D-1:0] + P_D'(k)];
`endif
    end
  end

  // Pointers, occupancy and per-entry status; flush acts exactly like reset.
  always_ff @(posedge clk) begin
    if (!rst || io.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_rdy   <= '0;
      r_occ   <= '0;
`ifdef NCPU_ROB_EXC_EN
      r_exc   <= '0;
`endif
    end else begin
      r_head  <= r_head + PTRW'(w_pop_n);
      r_tail  <= r_tail + PTRW'(w_push_n);
      r_count <= r_count + PTRW'(w_push_n) - PTRW'(w_pop_n);
      for (int k = 0; k < IW; k++) begin
        if (PIW1'(k) < w_push_n) begin
          r_rdy[r_tail[P_D-1:0] + P_D'(k)] <= 1'b0;
          r_occ[r_tail[P_D-1:0] + P_D'(k)] <= 1'b1;
`ifdef NCPU_ROB_EXC_EN
          r_exc[r_tail[P_D-1:0] + P_D'(k)] <= 1'b0;
`endif
        end
      end
      for (int p = 0; p < WBW; p++) begin
        if (io.wb_valid[p] && r_occ[io.wb_rob_id[p*P_D +: P_D]]) begin
          r_rdy[io.wb_rob_id[p*P_D +: P_D]] <= 1'b1;
`ifdef NCPU_ROB_EXC_EN
          r_exc[io.wb_rob_id[p*P_D +: P_D]] <= io.wb_exc[p];
`endif
        end
      end
      for (int k = 0; k < CW; k++) begin
        if (PCW1'(k) < w_pop_n) begin
          r_rdy[r_head[P_D-1:0] + P_D'(k)] <= 1'b0;
          r_occ[r_head[P_D-1:0] + P_D'(k)] <= 1'b0;
        end
      end
    end
  end

  // Payload and result storage; contents are only meaningful while occupied.
  always_ff @(posedge clk) begin
    if (rst && !io.flush) begin
      for (int k = 0; k < IW; k++) begin
        if (PIW1'(k) < w_push_n) begin
          r_payload[r_tail[P_D-1:0] + P_D'(k)] <= io.push_payload[k*PAYLOAD_DW +: PAYLOAD_DW];
        end
      end
      for (int p = 0; p < WBW; p++) begin
        if (io.wb_valid[p] && r_occ[io.wb_rob_id[p*P_D +: P_D]]) begin
          r_data[io.wb_rob_id[p*P_D +: P_D]] <= io.wb_data[p*CONFIG_DW +: CONFIG_DW];
        end
      end
    end
  end
endmodule

// File: tb/tb_rob_mw.sv
// tb_rob_mw: directed self-checking bench for rob_mw (D=16, IW=CW=WBW=2).
module tb_rob_mw;
  logic clk;
  logic rst;
  logic chk_en;
  int   n_chk;
  int   n_fail;

  rob_mw_if #(
    .CONFIG_P_ISSUE_WIDTH(1), .CONFIG_P_COMMIT_WIDTH(1), .CONFIG_P_WB_WIDTH(1),
    .CONFIG_P_ROB_DEPTH(4), .PAYLOAD_DW(96), .CONFIG_DW(64)
  ) bus ();

  rob_mw #(
    .CONFIG_P_ISSUE_WIDTH(1), .CONFIG_P_COMMIT_WIDTH(1), .CONFIG_P_WB_WIDTH(1),
    .CONFIG_P_ROB_DEPTH(4), .PAYLOAD_DW(96), .CONFIG_DW(64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  rob_mw_chk #(
    .CONFIG_P_COMMIT_WIDTH(1), .CONFIG_P_WB_WIDTH(1), .CONFIG_P_ROB_DEPTH(4)
  ) u_chk (
    .clk  (clk),
    .rst  (rst),
    .i_en (chk_en),
    .io   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush        = 1'b0;
    bus.push_size    = '0;
    bus.push_payload = '0;
    bus.wb_valid     = '0;
    bus.wb_rob_id    = '0;
    bus.wb_data      = '0;
    bus.cmt_pop_size = '0;
`ifdef NCPU_ROB_EXC_EN
    bus.wb_exc       = '0;
`endif
  endtask

  task automatic push(input int n, input int tag);
    bus.push_size    = 2'(n);
    bus.push_payload = {96'(tag + 1), 96'(tag)};
  endtask

  task automatic wb2(input logic [1:0] v, input int id0, input int id1,
                     input logic [63:0] d0, input logic [63:0] d1);
    bus.wb_valid  = v;
    bus.wb_rob_id = {4'(id1), 4'(id0)};
    bus.wb_data   = {d1, d0};
  endtask

  logic [63:0] tb_data [16];
  int tt;
  int hh;
  int pend0;
  int pend1;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    chk_en = 1'b1;
    rst    = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b1;

    // Reset state
    chk("rst_ready", 128'(bus.rob_ready), 128'(1'b1));
    chk("rst_empty", 128'(bus.rob_empty), 128'(1'b1));
    chk("rst_count", 128'(bus.rob_count), 128'(5'd0));
    chk("rst_valid", 128'(bus.cmt_valid), 128'(2'b00));
    chk("rst_free_id", 128'(bus.rob_free_id), 128'(8'h10));

    // Push ids 0,1 then 2,3
    push(2, 256); tick();
    chk("push2_count", 128'(bus.rob_count), 128'(5'd2));
    chk("push2_free_id", 128'(bus.rob_free_id), 128'(8'h32));
    chk("push2_empty", 128'(bus.rob_empty), 128'(1'b0));
    push(2, 258); tick(); idle();
    chk("push4_count", 128'(bus.rob_count), 128'(5'd4));

    // Out-of-order writeback: id1 first keeps window closed
    wb2(2'b01, 1, 0, 64'h1111, 64'h0); tick(); idle();
    chk("wb1_valid", 128'(bus.cmt_valid), 128'(2'b00));
    wb2(2'b01, 0, 0, 64'h0000_0000_0000_1000, 64'h0); tick(); idle();
    chk("wb0_valid", 128'(bus.cmt_valid), 128'(2'b11));
    chk("wb0_ids", 128'(bus.cmt_rob_id), 128'(8'h10));
    chk("wb0_data", 128'(bus.cmt_data), {64'h1111, 64'h1000});
    chk("wb0_payload0", 128'(bus.cmt_payload[95:0]), 128'(96'd256));
    chk("wb0_payload1", 128'(bus.cmt_payload[191:96]), 128'(96'd257));
    bus.cmt_pop_size = 2'd2; tick(); idle();
    chk("pop2_count", 128'(bus.rob_count), 128'(5'd2));
    chk("pop2_ids", 128'(bus.cmt_rob_id), 128'(8'h32));
    chk("pop2_valid", 128'(bus.cmt_valid), 128'(2'b00));
    wb2(2'b11, 2, 3, 64'h2, 64'h3); tick(); idle();
    chk("wb23_valid", 128'(bus.cmt_valid), 128'(2'b11));
    bus.cmt_pop_size = 2'd2; tick(); idle();
    chk("drain_empty", 128'(bus.rob_empty), 128'(1'b1));

    // Fill to 15 starting at index 4
    for (int i = 0; i < 7; i++) begin
      push(2, 512 + 2 * i); tick(); idle();
    end
    chk("fill14_count", 128'(bus.rob_count), 128'(5'd14));
    chk("fill14_ready", 128'(bus.rob_ready), 128'(1'b1));
    push(1, 600); tick(); idle();
    chk("fill15_count", 128'(bus.rob_count), 128'(5'd15));
    chk("fill15_ready", 128'(bus.rob_ready), 128'(1'b0));
    chk("fill15_free_id", 128'(bus.rob_free_id), 128'(8'h43));

    // Push while not ready is dropped
    chk_en = 1'b0;
    push(2, 700); tick(); idle();
    chk_en = 1'b1;
    chk("drop_count", 128'(bus.rob_count), 128'(5'd15));
    chk("drop_free_id", 128'(bus.rob_free_id), 128'(8'h43));

    // Pop one without push reopens space
    wb2(2'b01, 4, 0, 64'h4, 64'h0); tick(); idle();
    chk("pop1_valid", 128'(bus.cmt_valid), 128'(2'b01));
    bus.cmt_pop_size = 2'd1; tick(); idle();
    chk("pop1_count", 128'(bus.rob_count), 128'(5'd14));
    chk("pop1_ready", 128'(bus.rob_ready), 128'(1'b1));
    chk("pop1_ids", 128'(bus.cmt_rob_id), 128'(8'h65));
    for (int i = 0; i < 7; i++) begin
      wb2(2'b11, (5 + 2 * i) % 16, (6 + 2 * i) % 16, 64'(i), 64'(i)); tick(); idle();
    end
    for (int i = 0; i < 7; i++) begin
      bus.cmt_pop_size = 2'd2; tick(); idle();
    end
    chk("fill_drain_count", 128'(bus.rob_count), 128'(5'd0));
    chk("fill_drain_free_id", 128'(bus.rob_free_id), 128'(8'h43));

    // Streaming push/writeback/pop across the wrap boundary, head starts at 3
    tt = 3; hh = 3; pend0 = 0; pend1 = 0;
    for (int c = 0; c < 40; c++) begin
      idle();
      push(2, 1000 + 2 * c);
      if (c >= 1) begin
        tb_data[pend0] = 64'hD0D0_0000_0000_0000 + 64'(2 * c);
        tb_data[pend1] = 64'hD0D0_0000_0000_0000 + 64'(2 * c + 1);
        wb2(2'b11, pend0, pend1, tb_data[pend0], tb_data[pend1]);
      end
      if (c >= 2) begin
        chk("wrap_valid", 128'(bus.cmt_valid), 128'(2'b11));
        chk("wrap_ids", 128'(bus.cmt_rob_id), 128'({4'((hh + 1) % 16), 4'(hh)}));
        chk("wrap_data", 128'(bus.cmt_data), {tb_data[(hh + 1) % 16], tb_data[hh]});
        bus.cmt_pop_size = 2'd2;
        hh = (hh + 2) % 16;
      end
      pend0 = tt; pend1 = (tt + 1) % 16; tt = (tt + 2) % 16;
      tick();
      chk("wrap_count", 128'(bus.rob_count), 128'(5'((c == 0) ? 2 : 4)));
    end
    idle();
    tb_data[pend0] = 64'hEEEE_0000_0000_0000;
    tb_data[pend1] = 64'hEEEE_0000_0000_0001;
    wb2(2'b11, pend0, pend1, tb_data[pend0], tb_data[pend1]);
    chk("wrap_tail_ids", 128'(bus.cmt_rob_id), 128'({4'((hh + 1) % 16), 4'(hh)}));
    bus.cmt_pop_size = 2'd2; hh = (hh + 2) % 16;
    tick(); idle();
    chk("wrap_last_valid", 128'(bus.cmt_valid), 128'(2'b11));
    chk("wrap_last_data", 128'(bus.cmt_data), {tb_data[(hh + 1) % 16], tb_data[hh]});
    bus.cmt_pop_size = 2'd2; tick(); idle();
    chk("wrap_end_count", 128'(bus.rob_count), 128'(5'd0));
    chk("wrap_end_free_id", 128'(bus.rob_free_id), 128'(8'h43));

    // Flush with 9 entries and concurrent push/writeback
    for (int i = 0; i < 4; i++) begin
      push(2, 2000 + 2 * i); tick(); idle();
    end
    push(1, 2100); tick(); idle();
    wb2(2'b11, 3, 4, 64'h3, 64'h4); tick(); idle();
    chk("preflush_count", 128'(bus.rob_count), 128'(5'd9));
    chk("preflush_valid", 128'(bus.cmt_valid), 128'(2'b11));
    bus.flush = 1'b1;
    push(2, 2200);
    wb2(2'b01, 5, 0, 64'h5, 64'h0);
    tick(); idle();
    chk("flush_count", 128'(bus.rob_count), 128'(5'd0));
    chk("flush_empty", 128'(bus.rob_empty), 128'(1'b1));
    chk("flush_valid", 128'(bus.cmt_valid), 128'(2'b00));
    chk("flush_free_id", 128'(bus.rob_free_id), 128'(8'h10));
    chk("flush_ready", 128'(bus.rob_ready), 128'(1'b1));

    // Entries 0..2 written back; id1 may carry an exception
    push(2, 3000); tick(); idle();
    push(1, 3002); tick(); idle();
    wb2(2'b11, 0, 1, 64'hA0, 64'hA1);
`ifdef NCPU_ROB_EXC_EN
    bus.wb_exc = 2'b10;
`endif
    tick(); idle();
    wb2(2'b01, 2, 0, 64'hA2, 64'h0); tick(); idle();
`ifdef NCPU_ROB_EXC_EN
    chk("exc_valid_a", 128'(bus.cmt_valid), 128'(2'b01));
    chk("exc_flag_a", 128'(bus.cmt_exc), 128'(2'b00));
    bus.cmt_pop_size = 2'd1; tick(); idle();
    chk("exc_valid_b", 128'(bus.cmt_valid), 128'(2'b01));
    chk("exc_flag_b", 128'(bus.cmt_exc), 128'(2'b01));
    chk("exc_ids_b", 128'(bus.cmt_rob_id), 128'(8'h21));
`else
    chk("win_valid_a", 128'(bus.cmt_valid), 128'(2'b11));
    bus.cmt_pop_size = 2'd1; tick(); idle();
    chk("win_valid_b", 128'(bus.cmt_valid), 128'(2'b11));
    chk("win_ids_b", 128'(bus.cmt_rob_id), 128'(8'h21));
    chk("win_data_b", 128'(bus.cmt_data), {64'hA2, 64'hA1});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
